// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - shared encodings for the multiply/divide sequencer
//   state_t   : sequencer states
//   OP_*      : operation select encoding on the op input
//   ALU_*     : function codes driven on alu_af while the sequencer owns the ALU
package muldiv_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MUL     = 3'd1,
        ST_DIV_CMP = 3'd2,
        ST_DIV_SUB = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADDU = 4'b0001;
    localparam logic [3:0] ALU_SUBU = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b1011;

endpackage

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle unsigned MULTU/DIVU sequencer driving the shared ALU
//   clk, reset        : clock, asynchronous active-high reset
//   start, op, a, b   : request (sampled in IDLE), 0 = MULTU / 1 = DIVU, operands
//   busy, done        : non-IDLE indicator, one-cycle completion pulse
//   hi, lo            : product high/low or remainder/quotient, held until next completion
//   alu_own           : execute mux select for the ALU operand ports below
//   alu_a, alu_b      : ALU operands (0 when not owning)
//   alu_af, alu_i     : ALU function code, immediate select (always 0)
//   alu_res           : combinational ALU result
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         op,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] hi,
    output logic [n-1:0] lo,
    output logic         alu_own,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic [3:0]   alu_af,
    output logic         alu_i,
    input  logic [n-1:0] alu_res
);

    localparam logic [5:0] CNT_LAST = 6'(n - 1);

    state_t       state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    // acc: P_hi for multiply, partial remainder R for divide
    // sh : P_lo (multiplier) for multiply, quotient/dividend Q for divide
    // opd: multiplicand M for multiply, divisor D for divide
    logic [n-1:0] acc_q, acc_d;
    logic [n-1:0] sh_q, sh_d;
    logic [n-1:0] opd_q, opd_d;
    logic [n-1:0] hi_q, hi_d;
    logic [n-1:0] lo_q, lo_d;

    logic         last_iter;
    logic [n-1:0] div_shift;
    logic [n-1:0] sum;
    logic         carry;

    assign last_iter = (cnt_q == CNT_LAST);
    // Next partial remainder: R shifted left with the next dividend bit brought in.
    assign div_shift = {acc_q[n-2:0], sh_q[n-1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            opd_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            opd_q   <= opd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        opd_d   = opd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        alu_a   = '0;
        alu_b   = '0;
        alu_af  = ALU_NONE;
        sum     = '0;
        carry   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    acc_d = '0;
                    if (op == OP_MULTU) begin
                        sh_d    = b;
                        opd_d   = a;
                        state_d = ST_MUL;
                    end else if (b == '0) begin
                        hi_d    = a;
                        lo_d    = '1;
                        state_d = ST_DONE;
                    end else begin
                        sh_d    = a;
                        opd_d   = b;
                        state_d = ST_DIV_CMP;
                    end
                end
            end

            ST_MUL: begin
                if (sh_q[0]) begin
                    alu_a  = acc_q;
                    alu_b  = opd_q;
                    alu_af = ALU_ADDU;
                    sum    = alu_res;
                    // The ALU has no carry-out; an unsigned wrap shows as sum < addend.
                    carry  = (sum < acc_q);
                end else begin
                    sum    = acc_q;
                end
                acc_d = {carry, sum[n-1:1]};
                sh_d  = {sum[0], sh_q[n-1:1]};
                cnt_d = cnt_q + 6'd1;
                if (last_iter) begin
                    hi_d    = acc_d;
                    lo_d    = sh_d;
                    state_d = ST_DONE;
                end
            end

            ST_DIV_CMP: begin
                alu_a  = div_shift;
                alu_b  = opd_q;
                alu_af = ALU_SLTU;
                acc_d  = div_shift;
                sh_d   = {sh_q[n-2:0], 1'b0};
                // A bit shifted out of R means the true remainder exceeds 2^n > D.
                if (acc_q[n-1] || !alu_res[0]) begin
                    state_d = ST_DIV_SUB;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    if (last_iter) begin
                        hi_d    = acc_d;
                        lo_d    = sh_d;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DIV_SUB: begin
                // Modulo-2^n subtract is exact even when the shifted-out bit was set.
                alu_a  = acc_q;
                alu_b  = opd_q;
                alu_af = ALU_SUBU;
                acc_d  = alu_res;
                sh_d   = {sh_q[n-1:1], 1'b1};
                cnt_d  = cnt_q + 6'd1;
                if (last_iter) begin
                    hi_d    = acc_d;
                    lo_d    = sh_d;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DIV_CMP;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign alu_own = busy;
    assign alu_i   = 1'b0;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule
